pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- IF-stage block directly upstream of the IF/ID pipeline register.
- Owns the program counter and selects the next PC from three sources: sequential PC+4, taken branch, or jump.
- Fetches from a variable-latency instruction memory using a req/ack handshake.
- Presents the fetched instruction and its PC+4 to IF/ID. When no valid instruction is available, it presents a bubble.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- BUBBLE, 32'hFC000000, instruction word driven when no valid fetch exists. Equals the IF/ID flush encoding.
- MAX_WAIT, 15, number of consecutive un-acked request cycles before timeout_o sets.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- hd_i  in  1  hazard stall; IF/ID holds its contents while this is 1.
- branch_i  in  1  taken branch resolved in ID; also flushes IF/ID.
- branch_addr_i  in  32  branch target.
- jump_i  in  1  jump decoded in ID.
- jump_idx_i  in  26  jump instruction index field.
- id_pc4_i  in  32  PC+4 of the instruction currently in ID.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  32  request address; stable while imem_req_o=1.
- imem_ack_i  in  1  memory data valid; one cycle per request.
- imem_data_i  in  32  fetched instruction word.
- inst_addr_o  out  32  PC+4 of the instruction on inst_o; feeds IF/ID.
- inst_o  out  32  instruction word; feeds IF/ID.
- timeout_o  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (rst_i=1, synchronous; overrides everything, including mid-request):
  - pc=RESET_PC.
  - inst_o=BUBBLE, inst_addr_o=0.
  - imem_req_o=0, timeout_o=0, wait counter=0.
  - State=IDLE. A pending memory transaction is abandoned; a late ack is ignored.
- Redirect target:
  - Branch: branch_addr_i.
  - Jump: {id_pc4_i[31:28], jump_idx_i, 2'b00}.
  - branch_i has priority over jump_i. A redirect is any cycle where either is 1.
- States and transitions:
  - IDLE: req low. Next state FETCH.
  - FETCH, entry: on entry, latch req_addr=pc and assert imem_req_o. imem_addr_o=req_addr. Requests in this state:
    - must hold addr and req until ack;
    - may never be withdrawn except by reset.
  - FETCH, ack with no redirect and hd_i=0:
    - inst_o<=imem_data_i, inst_addr_o<=req_addr+4, pc<=req_addr+4.
    - Stay in FETCH; the new request issues the next cycle (one idle cycle between requests).
  - FETCH, ack with no redirect and hd_i=1:
    - Store the word in hold_buf. Outputs are unchanged.
    - req goes low. Next state HOLD.
  - FETCH, no ack and hd_i=0: inst_o<=BUBBLE (inst_addr_o unchanged).
  - FETCH, no ack and hd_i=1: outputs unchanged.
  - FETCH, redirect with ack in the same cycle:
    - Data is discarded. pc<=target, inst_o<=BUBBLE.
    - Stay in FETCH; the new request goes to target.
  - FETCH, redirect without ack:
    - pc<=target, inst_o<=BUBBLE. Next state DISCARD.
  - DISCARD:
    - req stays high at the old req_addr until ack; the ack data is dropped.
    - Next state FETCH; the request then goes to pc.
    - A further redirect in DISCARD overwrites pc with the new target.
  - HOLD:
    - req low; outputs unchanged while hd_i=1.
    - When hd_i=0: inst_o<=hold_buf, inst_addr_o<=req_addr+4, pc<=req_addr+4. Next state FETCH.
    - A redirect in HOLD drops hold_buf, sets pc<=target and inst_o<=BUBBLE, and goes to FETCH. A redirect beats the hold release in the same cycle.
- Wait counter (4-bit at default):
  - Counts consecutive cycles with imem_req_o=1 and no ack, in both FETCH and DISCARD.
  - Clears on ack.
  - When the count reaches MAX_WAIT, timeout_o<=1. The counter saturates.
  - timeout_o clears only on reset. Fetch continues waiting after timeout.
- Arithmetic: all PC math is 32-bit modulo 2^32, so 32'hFFFFFFFC+4 wraps to 0. Low two PC bits pass through unmodified; no alignment check.

Test Plan:
- Reset then zero-wait memory: rst_i held 2 cycles, ack every request cycle with data = 0x1000_0000+addr -> imem_addr_o sequence 0, 4, 8. inst_o/inst_addr_o pairs (0x1000_0000,4), (0x1000_0004,8). BUBBLE appears on the idle cycles between requests.
- 3-cycle memory latency on addr 0x8 -> inst_o=BUBBLE for the 3 wait cycles, imem_addr_o held at 8 throughout, then inst_o=data, inst_addr_o=0xC.
- Branch during wait: request to 0x10 outstanding, branch_i=1 with branch_addr_i=0x200 -> next ack data discarded. Following request address 0x200; inst_o=BUBBLE until the 0x200 word arrives. Same cycle with jump_i=1 as well -> branch still wins.
- Jump: id_pc4_i=0xA000_0010, jump_idx_i=0x0000040 -> next request address 0xA000_0100.
- Stall across ack: hd_i=1 when the word for 0x20 acks -> req low and outputs frozen. hd_i drops 4 cycles later -> inst_o=word, inst_addr_o=0x24, next request to 0x24. Repeat with branch_i during hold -> word dropped, request goes to the branch target.
- Timeout and reset mid-request: no ack for 15 cycles -> timeout_o=1 on the 15th. Assert rst_i -> timeout_o=0, req=0, pc=RESET_PC. A stale ack one cycle after reset leaves inst_o=BUBBLE.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - IF-stage PC owner and req/ack instruction fetcher feeding IF/ID
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] BUBBLE   = 32'hFC000000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hd_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        jump_i,
    input  logic [25:0] jump_idx_i,
    input  logic [31:0] id_pc4_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_o,
    output logic        timeout_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD, HOLD} state_t;

    state_t        state, state_n;
    logic          req, req_n;
    logic [31:0]   req_addr, req_addr_n;
    logic [31:0]   pc, pc_n;
    logic [31:0]   inst, inst_n;
    logic [31:0]   iaddr, iaddr_n;
    logic [31:0]   hold_buf, hold_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          timeout, timeout_n;

    logic          redirect;
    logic [31:0]   target;

    assign redirect    = branch_i | jump_i;
    assign target      = branch_i ? branch_addr_i : {id_pc4_i[31:28], jump_idx_i, 2'b00};

    assign imem_req_o  = req;
    assign imem_addr_o = req_addr;
    assign inst_o      = inst;
    assign inst_addr_o = iaddr;
    assign timeout_o   = timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            req      <= 1'b0;
            req_addr <= RESET_PC;
            pc       <= RESET_PC;
            inst     <= BUBBLE;
            iaddr    <= 32'h0;
            hold_buf <= BUBBLE;
            cnt      <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            req      <= req_n;
            req_addr <= req_addr_n;
            pc       <= pc_n;
            inst     <= inst_n;
            iaddr    <= iaddr_n;
            hold_buf <= hold_n;
            cnt      <= cnt_n;
            timeout  <= timeout_n;
        end
    end

    always_comb begin
        state_n    = state;
        req_n      = req;
        req_addr_n = req_addr;
        pc_n       = pc;
        inst_n     = inst;
        iaddr_n    = iaddr;
        hold_n     = hold_buf;
        cnt_n      = cnt;
        timeout_n  = timeout;

        // Wait counter only tracks cycles where a request is actually outstanding.
        if (req && !imem_ack_i) begin
            if (cnt != CW'(MAX_WAIT)) begin
                cnt_n = cnt + 1'b1;
            end
            if (cnt_n == CW'(MAX_WAIT)) begin
                timeout_n = 1'b1;
            end
        end else if (req && imem_ack_i) begin
            cnt_n = '0;
        end

        case (state)
            IDLE: begin
                state_n    = FETCH;
                req_n      = 1'b1;
                req_addr_n = pc;
            end
            FETCH: begin
                if (!req) begin
                    // Idle slot between requests; a redirect here just retargets the next one.
                    if (redirect) begin
                        pc_n   = target;
                        inst_n = BUBBLE;
                    end else begin
                        req_n      = 1'b1;
                        req_addr_n = pc;
                        if (!hd_i) begin
                            inst_n = BUBBLE;
                        end
                    end
                end else if (redirect) begin
                    pc_n   = target;
                    inst_n = BUBBLE;
                    if (imem_ack_i) begin
                        req_n = 1'b0;
                    end else begin
                        state_n = DISCARD;
                    end
                end else if (imem_ack_i) begin
                    req_n = 1'b0;
                    if (hd_i) begin
                        hold_n  = imem_data_i;
                        state_n = HOLD;
                    end else begin
                        inst_n  = imem_data_i;
                        iaddr_n = req_addr + 32'd4;
                        pc_n    = req_addr + 32'd4;
                    end
                end else if (!hd_i) begin
                    inst_n = BUBBLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_n   = target;
                    inst_n = BUBBLE;
                end
                if (imem_ack_i) begin
                    req_n   = 1'b0;
                    state_n = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n    = target;
                    inst_n  = BUBBLE;
                    state_n = FETCH;
                end else if (!hd_i) begin
                    inst_n  = hold_buf;
                    iaddr_n = req_addr + 32'd4;
                    pc_n    = req_addr + 32'd4;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
